pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the five-stage pipeline. It drives the enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards in ID and branch redirects, and runs a request/acknowledge handshake with a variable-latency data memory, with a watchdog timeout. It sits beside the pipeline registers in the CPU top level, and the pipeline registers gain enable/bubble inputs driven from it.

---
 rtl/pipeline_hazard_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use interlock, branch
// flush and a data-memory request/ack handshake guarded by a watchdog.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        IDEX_MemRead_i,
  input  logic [4:0]  IDEX_RD_i,
  input  logic [4:0]  IFID_RS1_i,
  input  logic [4:0]  IFID_RS2_i,
  input  logic        Branch_taken_i,
  input  logic        EXMEM_MemRead_i,
  input  logic        EXMEM_MemWrite_i,
  input  logic        dmem_ack_i,
  output logic        dmem_req_o,
  output logic        PC_en_o,
  output logic        IFID_en_o,
  output logic        IDEX_en_o,
  output logic        EXMEM_en_o,
  output logic        MEMWB_en_o,
  output logic        IFID_flush_o,
  output logic        IDEX_bubble_o,
  output logic        MEMWB_bubble_o,
  output logic        err_o,
  output logic [15:0] stall_cycles_o
);

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt, cnt_inc;
  logic [15:0]        stall_cycles, stall_cycles_nxt;
  logic               mem_acc, mem_stall, load_use, hazard_raw, in_err;

  assign in_err     = (state == ERR);
  assign mem_acc    = EXMEM_MemRead_i | EXMEM_MemWrite_i;
  assign hazard_raw = IDEX_MemRead_i && (IDEX_RD_i != 5'd0) &&
                      ((IDEX_RD_i == IFID_RS1_i) || (IDEX_RD_i == IFID_RS2_i));
  assign mem_stall  = dmem_req_o & ~dmem_ack_i;
  // Memory stall and ERR both mask the interlock; it is re-evaluated on the ack cycle.
  assign load_use   = hazard_raw & ~mem_stall & ~in_err;
  assign cnt_inc    = wait_cnt + 1'b1;

  assign dmem_req_o     = mem_acc & ~in_err;
  assign err_o          = in_err;
  assign stall_cycles_o = stall_cycles;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
    end else begin
      state        <= state_nxt;
      wait_cnt     <= wait_cnt_nxt;
      stall_cycles <= stall_cycles_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    wait_cnt_nxt     = wait_cnt;
    stall_cycles_nxt = stall_cycles;
    PC_en_o          = 1'b1;
    IFID_en_o        = 1'b1;
    IDEX_en_o        = 1'b1;
    EXMEM_en_o       = 1'b1;
    MEMWB_en_o       = 1'b1;
    IDEX_bubble_o    = 1'b0;
    MEMWB_bubble_o   = 1'b0;
    IFID_flush_o     = 1'b0;

    if (in_err) begin
      PC_en_o    = 1'b0;
      IFID_en_o  = 1'b0;
      IDEX_en_o  = 1'b0;
      EXMEM_en_o = 1'b0;
      MEMWB_en_o = 1'b0;
    end else if (mem_stall) begin
      PC_en_o        = 1'b0;
      IFID_en_o      = 1'b0;
      IDEX_en_o      = 1'b0;
      EXMEM_en_o     = 1'b0;
      MEMWB_en_o     = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else if (load_use) begin
      PC_en_o       = 1'b0;
      IFID_en_o     = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else begin
      IFID_flush_o = Branch_taken_i;
    end

    if (!in_err && (mem_stall || load_use) && (stall_cycles != 16'hFFFF))
      stall_cycles_nxt = stall_cycles + 16'd1;

    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt    = WAIT;
          wait_cnt_nxt = {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      WAIT: begin
        if (dmem_ack_i || !mem_acc) begin
          state_nxt = RUN;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_nxt = ERR;
        end else begin
          wait_cnt_nxt = cnt_inc;
        end
      end
      ERR: state_nxt = ERR;
      default: state_nxt = RUN;
    endcase
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short watchdog (TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        IDEX_MemRead_i;
  logic [4:0]  IDEX_RD_i, IFID_RS1_i, IFID_RS2_i;
  logic        Branch_taken_i, EXMEM_MemRead_i, EXMEM_MemWrite_i, dmem_ack_i;
  logic        dmem_req_o, PC_en_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o;
  logic        IFID_flush_o, IDEX_bubble_o, MEMWB_bubble_o, err_o;
  logic [15:0] stall_cycles_o;
  logic [9:0]  outs;

  int checks = 0;
  int errors = 0;
  int unsigned exp_stall = 0;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_RD_i(IDEX_RD_i),
    .IFID_RS1_i(IFID_RS1_i), .IFID_RS2_i(IFID_RS2_i),
    .Branch_taken_i(Branch_taken_i),
    .EXMEM_MemRead_i(EXMEM_MemRead_i), .EXMEM_MemWrite_i(EXMEM_MemWrite_i),
    .dmem_ack_i(dmem_ack_i), .dmem_req_o(dmem_req_o),
    .PC_en_o(PC_en_o), .IFID_en_o(IFID_en_o), .IDEX_en_o(IDEX_en_o),
    .EXMEM_en_o(EXMEM_en_o), .MEMWB_en_o(MEMWB_en_o),
    .IFID_flush_o(IFID_flush_o), .IDEX_bubble_o(IDEX_bubble_o),
    .MEMWB_bubble_o(MEMWB_bubble_o), .err_o(err_o),
    .stall_cycles_o(stall_cycles_o)
  );

  always #5 clk_i = ~clk_i;

  // {PC, IFID, IDEX, EXMEM, MEMWB enables, flush, IDEX bubble, MEMWB bubble, req, err}
  assign outs = {PC_en_o, IFID_en_o, IDEX_en_o, EXMEM_en_o, MEMWB_en_o,
                 IFID_flush_o, IDEX_bubble_o, MEMWB_bubble_o, dmem_req_o, err_o};

  localparam logic [9:0] O_IDLE   = 10'b11111_00000;
  localparam logic [9:0] O_IDLE_R = 10'b11111_00010;
  localparam logic [9:0] O_LU_R   = 10'b00111_01010;
  localparam logic [9:0] O_FLUSH  = 10'b11111_10000;
  localparam logic [9:0] O_MEMST  = 10'b00000_00110;
  localparam logic [9:0] O_ERR    = 10'b00000_00001;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    IDEX_MemRead_i = 0; IDEX_RD_i = 0; IFID_RS1_i = 0; IFID_RS2_i = 0;
    Branch_taken_i = 0; EXMEM_MemRead_i = 0; EXMEM_MemWrite_i = 0; dmem_ack_i = 0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    IDEX_MemRead_i = 1; IDEX_RD_i = rd; IFID_RS1_i = rd; IFID_RS2_i = 5'd1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 0;
    tick(); tick();
    rst_i = 1;
    exp_stall = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== O_IDLE) begin
        errors++; $display("FAIL reset_outs cyc%0d got %b exp %b", i, outs, O_IDLE);
      end
      checks++;
      if (stall_cycles_o !== 16'd0) begin
        errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles_o);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    set_load_use(5'd5);
    EXMEM_MemRead_i = 1; dmem_ack_i = 1;
    #1;
    checks++;
    if (outs !== O_LU_R) begin
      errors++; $display("FAIL load_use_outs got %b exp %b", outs, O_LU_R);
    end
    tick();
    exp_stall++;
    IDEX_MemRead_i = 0;
    #1;
    checks++;
    if (outs !== O_IDLE_R) begin
      errors++; $display("FAIL load_use_release got %b exp %b", outs, O_IDLE_R);
    end
    checks++;
    if (stall_cycles_o !== 16'(exp_stall)) begin
      errors++; $display("FAIL load_use_count got %0d exp %0d", stall_cycles_o, exp_stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_no_hazard();
    set_load_use(5'd0);
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL rd_zero_outs got %b exp %b", outs, O_IDLE);
    end
    tick();
    idle_inputs();
    Branch_taken_i = 1;
    #1;
    checks++;
    if (outs !== O_FLUSH) begin
      errors++; $display("FAIL branch_flush got %b exp %b", outs, O_FLUSH);
    end
    tick();
    Branch_taken_i = 0;
    #1;
    checks++;
    if (outs !== O_IDLE) begin
      errors++; $display("FAIL branch_after got %b exp %b", outs, O_IDLE);
    end
    checks++;
    if (stall_cycles_o !== 16'(exp_stall)) begin
      errors++; $display("FAIL no_hazard_count got %0d exp %0d", stall_cycles_o, exp_stall);
    end
    tick();
  endtask

  task automatic test_mem_latency();
    EXMEM_MemRead_i = 1; dmem_ack_i = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== O_MEMST) begin
        errors++; $display("FAIL mem_wait cyc%0d got %b exp %b", i, outs, O_MEMST);
      end
      tick();
    end
    dmem_ack_i = 1;
    #1;
    checks++;
    if (outs !== O_IDLE_R) begin
      errors++; $display("FAIL mem_ack got %b exp %b", outs, O_IDLE_R);
    end
    tick();
    exp_stall += 3;
    // back-to-back access straight after the ack must stall again from RUN
    dmem_ack_i = 0;
    #1;
    checks++;
    if (outs !== O_MEMST) begin
      errors++; $display("FAIL b2b_stall got %b exp %b", outs, O_MEMST);
    end
    tick();
    dmem_ack_i = 1;
    #1;
    checks++;
    if (outs !== O_IDLE_R) begin
      errors++; $display("FAIL b2b_ack got %b exp %b", outs, O_IDLE_R);
    end
    tick();
    exp_stall += 1;
    idle_inputs();
    #1;
    checks++;
    if (stall_cycles_o !== 16'(exp_stall)) begin
      errors++; $display("FAIL mem_count got %0d exp %0d", stall_cycles_o, exp_stall);
    end
  endtask

  task automatic test_combined();
    set_load_use(5'd7);
    Branch_taken_i = 1; EXMEM_MemRead_i = 1; dmem_ack_i = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (outs !== O_MEMST) begin
        errors++; $display("FAIL combo_stall cyc%0d got %b exp %b", i, outs, O_MEMST);
      end
      tick();
    end
    dmem_ack_i = 1;
    #1;
    checks++;
    if (outs !== O_LU_R) begin
      errors++; $display("FAIL combo_ack got %b exp %b", outs, O_LU_R);
    end
    tick();
    exp_stall += 3;
    idle_inputs();
    #1;
    checks++;
    if (stall_cycles_o !== 16'(exp_stall)) begin
      errors++; $display("FAIL combo_count got %0d exp %0d", stall_cycles_o, exp_stall);
    end
    tick();
  endtask

  task automatic test_timeout();
    EXMEM_MemWrite_i = 1; dmem_ack_i = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (outs !== O_MEMST) begin
        errors++; $display("FAIL timeout_stall cyc%0d got %b exp %b", i, outs, O_MEMST);
      end
      tick();
    end
    exp_stall += 4;
    #1;
    checks++;
    if (outs !== O_ERR) begin
      errors++; $display("FAIL timeout_err got %b exp %b", outs, O_ERR);
    end
    dmem_ack_i = 1;
    set_load_use(5'd3);
    Branch_taken_i = 1;
    tick(); tick();
    checks++;
    if (outs !== O_ERR) begin
      errors++; $display("FAIL err_sticky got %b exp %b", outs, O_ERR);
    end
    checks++;
    if (stall_cycles_o !== 16'(exp_stall)) begin
      errors++; $display("FAIL err_count got %0d exp %0d", stall_cycles_o, exp_stall);
    end
    rst_i = 0;
    tick();
    rst_i = 1;
    idle_inputs();
    exp_stall = 0;
    #1;
    checks++;
    if (outs !== O_IDLE || stall_cycles_o !== 16'd0) begin
      errors++; $display("FAIL err_reset got %b/%0d exp %b/0", outs, stall_cycles_o, O_IDLE);
    end
    tick();
  endtask

  task automatic test_saturation();
    set_load_use(5'd9);
    for (int i = 0; i < 65540; i++) tick();
    checks++;
    if (stall_cycles_o !== 16'hFFFF) begin
      errors++; $display("FAIL saturate got %h exp ffff", stall_cycles_o);
    end
    tick();
    checks++;
    if (stall_cycles_o !== 16'hFFFF) begin
      errors++; $display("FAIL saturate_hold got %h exp ffff", stall_cycles_o);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_i = 0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mem_latency();
    test_combined();
    test_timeout();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
